// File: rtl/mem_stage_unit.sv
// MEM pipeline stage: data-memory access over req/ack with timeout, writeback select, MEM/WB register.
// Optional misaligned-access rejection when MEM_ALIGN_CHECK_EN is defined.
module mem_stage_unit #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] ex_alu_result,
  input  logic [63:0] ex_lsr_result,
  input  logic [63:0] ex_write_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_mem_to_reg,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        stall,
  output logic        mem_err,
  output logic [63:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_nextState;
  logic [7:0]  r_count;
  logic        w_memOp;
  logic        w_alignErr;
  logic        w_issue;
  logic        w_ackHit;
  logic        w_timeout;
  logic [63:0] w_wbSel;

  always_comb begin
    w_memOp = ex_mem_write | (ex_mem_to_reg == 2'b01);
`ifdef MEM_ALIGN_CHECK_EN
    w_alignErr = (r_state == S_IDLE) & w_memOp & (|ex_alu_result[2:0]);
`else
    w_alignErr = 1'b0;
`endif
    w_issue   = (r_state == S_IDLE) & w_memOp & ~w_alignErr;
    w_ackHit  = (r_state == S_REQ) & dmem_ack;
    w_timeout = (r_state == S_REQ) & ~dmem_ack & (r_count == TIMEOUT_LAST);
    stall     = w_issue | ((r_state == S_REQ) & ~dmem_ack & ~w_timeout);

    w_nextState = r_state;
    if (w_issue)
      w_nextState = S_REQ;
    else if (w_ackHit | w_timeout)
      w_nextState = S_IDLE;

    // Encoding 11 falls back to the ALU result.
    case (ex_mem_to_reg)
      2'b01:   w_wbSel = dmem_rdata;
      2'b10:   w_wbSel = ex_lsr_result;
      default: w_wbSel = ex_alu_result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_count    <= 8'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 64'd0;
      dmem_wdata <= 64'd0;
      mem_err    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_issue) begin
        dmem_req   <= 1'b1;
        dmem_we    <= ex_mem_write;
        dmem_addr  <= ex_alu_result;
        dmem_wdata <= ex_write_data;
        r_count    <= 8'd0;
      end else if (r_state == S_REQ) begin
        if (w_ackHit | w_timeout)
          dmem_req <= 1'b0;
        else
          r_count <= r_count + 8'd1;
      end
      if (w_timeout | w_alignErr)
        mem_err <= 1'b1;
    end
  end

  // Stalls, timeouts and rejected accesses all insert a bubble that keeps the last data/rd.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_data      <= 64'd0;
      wb_rd        <= 5'd0;
      wb_reg_write <= 1'b0;
    end else if (stall | w_timeout | w_alignErr) begin
      wb_reg_write <= 1'b0;
    end else begin
      wb_data      <= w_wbSel;
      wb_rd        <= ex_rd;
      wb_reg_write <= ex_reg_write & (ex_rd != 5'd31);
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed testbench for mem_stage_unit (MEM_TIMEOUT=4); align-check scenario only when MEM_ALIGN_CHECK_EN is defined.
module tb_mem_stage_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] ex_alu_result, ex_lsr_result, ex_write_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_write;
  logic [1:0]  ex_mem_to_reg;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        stall, mem_err;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;

  int nChecks = 0;
  int nFails  = 0;

  mem_stage_unit #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .ex_alu_result(ex_alu_result), .ex_lsr_result(ex_lsr_result),
    .ex_write_data(ex_write_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .mem_err(mem_err), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    ex_alu_result = 64'd0; ex_lsr_result = 64'd0; ex_write_data = 64'd0;
    ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_write = 1'b0; ex_mem_to_reg = 2'b00;
    dmem_ack = 1'b0; dmem_rdata = 64'd0;
  endtask

  task automatic drive_op(input logic [63:0] alu, input logic [4:0] rd, input logic rw,
                          input logic mw, input logic [1:0] sel, input logic [63:0] wd);
    ex_alu_result = alu; ex_rd = rd; ex_reg_write = rw;
    ex_mem_write = mw; ex_mem_to_reg = sel; ex_write_data = wd;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_nop();
    tick(); tick();
    reset = 1'b0;
    #1;
    nChecks++; if (dmem_req !== 1'b0) begin nFails++; $display("[TB] FAIL reset_req: got %b expected 0", dmem_req); end
    nChecks++; if (dmem_we !== 1'b0 || dmem_addr !== 64'd0 || dmem_wdata !== 64'd0) begin nFails++; $display("[TB] FAIL reset_dmem: got we=%b addr=%h wdata=%h expected all 0", dmem_we, dmem_addr, dmem_wdata); end
    nChecks++; if (mem_err !== 1'b0) begin nFails++; $display("[TB] FAIL reset_err: got %b expected 0", mem_err); end
    nChecks++; if (wb_data !== 64'd0 || wb_rd !== 5'd0 || wb_reg_write !== 1'b0) begin nFails++; $display("[TB] FAIL reset_wb: got data=%h rd=%0d we=%b expected all 0", wb_data, wb_rd, wb_reg_write); end
    nChecks++; if (stall !== 1'b0) begin nFails++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
  endtask

  task automatic test_alu_op();
    drive_op(64'h10, 5'd3, 1'b1, 1'b0, 2'b00, 64'd0);
    #1;
    nChecks++; if (stall !== 1'b0) begin nFails++; $display("[TB] FAIL alu_stall: got %b expected 0", stall); end
    tick();
    drive_nop();
    nChecks++; if (wb_data !== 64'h10 || wb_rd !== 5'd3 || wb_reg_write !== 1'b1) begin nFails++; $display("[TB] FAIL alu_wb: got data=%h rd=%0d we=%b expected 10/3/1", wb_data, wb_rd, wb_reg_write); end
    nChecks++; if (dmem_req !== 1'b0) begin nFails++; $display("[TB] FAIL alu_req: got %b expected 0", dmem_req); end
  endtask

  task automatic test_wb_select();
    ex_lsr_result = 64'hABC;
    drive_op(64'h99, 5'd4, 1'b1, 1'b0, 2'b10, 64'd0);
    tick();
    nChecks++; if (wb_data !== 64'hABC || wb_rd !== 5'd4 || wb_reg_write !== 1'b1) begin nFails++; $display("[TB] FAIL lsr_wb: got data=%h rd=%0d we=%b expected abc/4/1", wb_data, wb_rd, wb_reg_write); end
    drive_op(64'h77, 5'd31, 1'b1, 1'b0, 2'b11, 64'd0);
    tick();
    drive_nop();
    nChecks++; if (wb_data !== 64'h77 || wb_rd !== 5'd31 || wb_reg_write !== 1'b0) begin nFails++; $display("[TB] FAIL sel11_x31: got data=%h rd=%0d we=%b expected 77/31/0", wb_data, wb_rd, wb_reg_write); end
  endtask

  task automatic test_load_fast();
    drive_op(64'h40, 5'd5, 1'b1, 1'b0, 2'b01, 64'd0);
    #1;
    nChecks++; if (stall !== 1'b1) begin nFails++; $display("[TB] FAIL ld_idle_stall: got %b expected 1", stall); end
    tick();
    nChecks++; if (dmem_req !== 1'b1 || dmem_addr !== 64'h40 || dmem_we !== 1'b0) begin nFails++; $display("[TB] FAIL ld_req: got req=%b addr=%h we=%b expected 1/40/0", dmem_req, dmem_addr, dmem_we); end
    dmem_ack = 1'b1; dmem_rdata = 64'hDEAD;
    #1;
    nChecks++; if (stall !== 1'b0) begin nFails++; $display("[TB] FAIL ld_ack_stall: got %b expected 0", stall); end
    nChecks++; if (wb_reg_write !== 1'b0) begin nFails++; $display("[TB] FAIL ld_bubble: got %b expected 0", wb_reg_write); end
    tick();
    drive_nop();
    nChecks++; if (dmem_req !== 1'b0) begin nFails++; $display("[TB] FAIL ld_req_drop: got %b expected 0", dmem_req); end
    nChecks++; if (wb_data !== 64'hDEAD || wb_rd !== 5'd5 || wb_reg_write !== 1'b1) begin nFails++; $display("[TB] FAIL ld_wb: got data=%h rd=%0d we=%b expected dead/5/1", wb_data, wb_rd, wb_reg_write); end
  endtask

  task automatic test_store_slow();
    int stalls = 0;
    drive_op(64'h80, 5'd6, 1'b0, 1'b1, 2'b00, 64'h1234);
    #1;
    if (stall === 1'b1) stalls++;
    tick();
    for (int i = 0; i < 4; i++) begin
      dmem_ack = (i == 3);
      #1;
      if (stall === 1'b1) stalls++;
      nChecks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 64'h80 || dmem_wdata !== 64'h1234) begin nFails++; $display("[TB] FAIL st_hold[%0d]: got req=%b we=%b addr=%h wdata=%h expected 1/1/80/1234", i, dmem_req, dmem_we, dmem_addr, dmem_wdata); end
      nChecks++; if (wb_reg_write !== 1'b0) begin nFails++; $display("[TB] FAIL st_wbwe[%0d]: got %b expected 0", i, wb_reg_write); end
      tick();
    end
    drive_nop();
    nChecks++; if (stalls != 4) begin nFails++; $display("[TB] FAIL st_stall_cycles: got %0d expected 4", stalls); end
    nChecks++; if (dmem_req !== 1'b0 || wb_reg_write !== 1'b0) begin nFails++; $display("[TB] FAIL st_done: got req=%b wbwe=%b expected 0/0", dmem_req, wb_reg_write); end
  endtask

  task automatic test_back_to_back();
    drive_op(64'h48, 5'd10, 1'b1, 1'b0, 2'b01, 64'd0);
    tick();
    dmem_ack = 1'b1; dmem_rdata = 64'h1111;
    tick();
    dmem_ack = 1'b0;
    drive_op(64'h50, 5'd11, 1'b1, 1'b0, 2'b01, 64'd0);
    #1;
    nChecks++; if (dmem_req !== 1'b0 || stall !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_idle: got req=%b stall=%b expected 0/1", dmem_req, stall); end
    nChecks++; if (wb_data !== 64'h1111 || wb_rd !== 5'd10 || wb_reg_write !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_wb1: got data=%h rd=%0d we=%b expected 1111/10/1", wb_data, wb_rd, wb_reg_write); end
    tick();
    nChecks++; if (dmem_req !== 1'b1 || dmem_addr !== 64'h50) begin nFails++; $display("[TB] FAIL b2b_req2: got req=%b addr=%h expected 1/50", dmem_req, dmem_addr); end
    dmem_ack = 1'b1; dmem_rdata = 64'h2222;
    tick();
    drive_nop();
    nChecks++; if (wb_data !== 64'h2222 || wb_rd !== 5'd11 || wb_reg_write !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_wb2: got data=%h rd=%0d we=%b expected 2222/11/1", wb_data, wb_rd, wb_reg_write); end
  endtask

  task automatic test_timeout();
    int reqCycles = 0;
    drive_op(64'h100, 5'd7, 1'b1, 1'b0, 2'b01, 64'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      if (dmem_req === 1'b1) reqCycles++;
      nChecks++; if (stall !== (i != 3)) begin nFails++; $display("[TB] FAIL to_stall[%0d]: got %b expected %b", i, stall, (i != 3)); end
      tick();
    end
    nChecks++; if (reqCycles != 4 || dmem_req !== 1'b0) begin nFails++; $display("[TB] FAIL to_req: got cycles=%0d req=%b expected 4/0", reqCycles, dmem_req); end
    nChecks++; if (mem_err !== 1'b1 || wb_reg_write !== 1'b0) begin nFails++; $display("[TB] FAIL to_err: got err=%b wbwe=%b expected 1/0", mem_err, wb_reg_write); end
    drive_op(64'h55, 5'd9, 1'b1, 1'b0, 2'b00, 64'd0);
    tick();
    drive_nop();
    nChecks++; if (wb_data !== 64'h55 || wb_rd !== 5'd9 || wb_reg_write !== 1'b1 || mem_err !== 1'b1) begin nFails++; $display("[TB] FAIL to_after: got data=%h rd=%0d we=%b err=%b expected 55/9/1/1", wb_data, wb_rd, wb_reg_write, mem_err); end
  endtask

  task automatic test_reset_mid();
    drive_op(64'h200, 5'd31, 1'b1, 1'b0, 2'b01, 64'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive_nop();
    dmem_ack = 1'b1; dmem_rdata = 64'hBEEF;
    #1;
    nChecks++; if (dmem_req !== 1'b0 || mem_err !== 1'b0 || dmem_addr !== 64'd0 || stall !== 1'b0) begin nFails++; $display("[TB] FAIL rst_mid: got req=%b err=%b addr=%h stall=%b expected all 0", dmem_req, mem_err, dmem_addr, stall); end
    nChecks++; if (wb_data !== 64'd0 || wb_rd !== 5'd0 || wb_reg_write !== 1'b0) begin nFails++; $display("[TB] FAIL rst_mid_wb: got data=%h rd=%0d we=%b expected all 0", wb_data, wb_rd, wb_reg_write); end
    tick();
    dmem_ack = 1'b0;
    nChecks++; if (dmem_req !== 1'b0 || wb_reg_write !== 1'b0 || wb_data !== 64'd0) begin nFails++; $display("[TB] FAIL late_ack: got req=%b we=%b data=%h expected 0/0/0", dmem_req, wb_reg_write, wb_data); end
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_align();
    drive_op(64'h43, 5'd8, 1'b1, 1'b0, 2'b01, 64'd0);
    #1;
    nChecks++; if (stall !== 1'b0) begin nFails++; $display("[TB] FAIL al_stall: got %b expected 0", stall); end
    tick();
    drive_nop();
    nChecks++; if (dmem_req !== 1'b0 || mem_err !== 1'b1 || wb_reg_write !== 1'b0) begin nFails++; $display("[TB] FAIL al_err: got req=%b err=%b wbwe=%b expected 0/1/0", dmem_req, mem_err, wb_reg_write); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_op();
    test_wb_select();
    test_load_fast();
    test_store_slow();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
`ifdef MEM_ALIGN_CHECK_EN
    test_align();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/mem_stage_unit.md
Name: mem_stage_unit

Overview:
- Consumer of the EX/MEM pipeline register outputs: performs the data-memory access for LDUR/STUR over a req/ack handshake and selects the writeback value (ALU, memory or shifter).
- Drives a stall to the hazard unit while an access is outstanding.
- Owns the MEM/WB register, so WB sees registered data, destination and write-enable.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles in REQ without dmem_ack before the access is abandoned; legal range 1..255.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- ex_alu_result  input  64  EX/MEM ALU result; memory address for loads and stores
- ex_lsr_result  input  64  EX/MEM shifter result
- ex_write_data  input  64  EX/MEM store data
- ex_rd  input  5  EX/MEM destination register
- ex_reg_write  input  1  EX/MEM register-write enable
- ex_mem_write  input  1  EX/MEM store enable
- ex_mem_to_reg  input  2  writeback select: 00 ALU, 01 memory (load), 10 LSR, 11 treated as 00
- dmem_req  output  1  memory request, registered
- dmem_we  output  1  1 = store, 0 = load; registered
- dmem_addr  output  64  access address; registered
- dmem_wdata  output  64  store data; registered
- dmem_ack  input  1  memory completion; sampled only while dmem_req=1
- dmem_rdata  input  64  load data; valid in the cycle dmem_ack=1
- stall  output  1  combinational; 1 = hold the IF/ID/EX pipeline registers and the EX/MEM register
- mem_err  output  1  sticky timeout or misalign flag
- wb_data  output  64  MEM/WB writeback value
- wb_rd  output  5  MEM/WB destination register
- wb_reg_write  output  1  MEM/WB write enable

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. At reset: state=IDLE, timeout counter=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, mem_err=0, wb_data=0, wb_rd=0, wb_reg_write=0.
- A reset asserted mid-access drops dmem_req on the next edge; a late dmem_ack is then ignored.
- mem_op = ex_mem_write | (ex_mem_to_reg==01).
- FSM IDLE -> REQ:
  - IDLE with mem_op=1: stall=1. Next edge: load dmem_addr/dmem_we/dmem_wdata from the EX inputs, set dmem_req=1, clear the counter, go to REQ.
  - IDLE with mem_op=0: stall=0; the instruction completes in 1 cycle.
- FSM in REQ:
  - dmem_req=1. Address, we and wdata stay stable until ack or timeout.
  - dmem_ack=0: stall=1, counter increments.
  - dmem_ack=1: stall=0 in that same cycle. Next edge: dmem_req=0, go to IDLE, MEM/WB captures the result.
  - Counter reaches MEM_TIMEOUT-1 with no ack: stall=0 that cycle. Next edge: dmem_req=0, go to IDLE, mem_err=1, MEM/WB loads a bubble.
- Minimum access latency is 2 cycles (ack in the first REQ cycle). An N-cycle ack costs N+1 stall cycles.
- Back-to-back memory ops: the second op re-enters IDLE -> REQ; there is no pipelining of requests.
- MEM/WB update, every edge:
  - If stall=1: load a bubble (wb_reg_write=0; wb_data and wb_rd hold).
  - Otherwise: wb_rd=ex_rd, and wb_data per ex_mem_to_reg: ALU -> ex_alu_result; memory -> dmem_rdata; LSR -> ex_lsr_result.
  - wb_reg_write = ex_reg_write & (ex_rd != 31) & ~timeout.
- A store with ex_reg_write=0 produces wb_reg_write=0.
- mem_err stays 1 until reset; it does not block later accesses.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - A mem_op with ex_alu_result[2:0] != 0 issues no request and stays in IDLE; stall=0.
  - mem_err=1 on the next edge and MEM/WB loads a bubble.
  - Aligned accesses are unchanged.
- Undefined: no check; the address is passed to memory unmodified.

Test Plan:
- Reset, then ALU op (ex_alu_result=0x10, ex_rd=3, ex_reg_write=1, ex_mem_to_reg=00) -> stall=0; next cycle wb_data=0x10, wb_rd=3, wb_reg_write=1; dmem_req never asserts.
- Load from addr 0x40, memory acks in first REQ cycle with rdata=0xDEAD -> stall=1 for exactly 1 cycle; dmem_req high 1 cycle with dmem_addr=0x40, dmem_we=0; wb_data=0xDEAD, wb_reg_write=1.
- Store to addr 0x80, data=0x1234, ack delayed 3 cycles -> dmem_we=1, dmem_wdata=0x1234 held stable for 4 REQ cycles; stall high 4 cycles; wb_reg_write=0 throughout.
- Load with no ack, MEM_TIMEOUT=4 -> dmem_req high exactly 4 cycles then low; mem_err=1; wb_reg_write=0; the next ALU op writes back normally.
- Load to rd=31, then reset asserted in REQ cycle 2 -> no write to x31; after reset all outputs are 0; a dmem_ack arriving after reset has no effect.
- With MEM_ALIGN_CHECK_EN defined: load at addr 0x43 -> dmem_req stays 0, stall=0, mem_err=1 next cycle, wb_reg_write=0.
